lane_judge: RTL and testbench

// - Consumer end of the tick generator: takes its one-cycle tick strobe and scrolls one drum lane of notes.
// - Judges player drum hits against a hit zone at the bottom of the lane.
// - Keeps score, combo and miss counts; ends the game after too many misses.
// - Sits between the tick generator / note pattern source and the VGA and score display logic.

---
 rtl/lane_judge.sv | 147 ++++++++++++++
 tb/tb_lane_judge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_judge.sv
// Single drum lane: scrolls notes on each tick, judges hits in the bottom zone, keeps score/combo/misses.
// Optional COMBO_BONUS_EN: good hits are worth 2 points once the running combo has reached 8.
module lane_judge #(
  parameter int LANE_LEN   = 16,
  parameter int HIT_ZONE   = 2,
  parameter int SCORE_W    = 10,
  parameter int COMBO_W    = 6,
  parameter int MAX_FALLOS = 8
) (
  input  logic                clk,
  input  logic                stop,
  input  logic                start,
  input  logic                tick,
  input  logic                note_in,
  input  logic                hit,
  output logic [LANE_LEN-1:0] lane,
  output logic [SCORE_W-1:0]  score,
  output logic [COMBO_W-1:0]  combo,
  output logic [3:0]          fallos,
  output logic                acierto,
  output logic                fallo,
  output logic                fin,
  output logic [1:0]          dbg_state
);

  // Handshake: start, tick and hit are single-cycle strobes sampled on every rising clk edge;
  // there is no back-pressure, and every output reflects the strobes of the previous cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  function automatic logic [LANE_LEN-1:0] f_zone_mask();
    logic [LANE_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < HIT_ZONE; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [LANE_LEN-1:0] ZONE_MASK = f_zone_mask();

  state_t              r_state, w_state_nx;
  logic [LANE_LEN-1:0] r_lane, w_lane_nx, w_lane_mid;
  logic [SCORE_W-1:0]  r_score, w_score_nx, w_score_inc;
  logic [COMBO_W-1:0]  r_combo, w_combo_nx, w_combo_inc;
  logic [3:0]          r_fallos, w_fallos_nx, w_fallos_inc;
  logic                r_acierto, w_acierto_nx;
  logic                r_fallo, w_fallo_nx;

  logic [LANE_LEN-1:0] w_zone, w_lowbit;
  logic [1:0]          w_score_step;
  logic [SCORE_W:0]    w_score_sum;

  // Isolate the lowest occupied zone position so a single hit clears exactly one note.
  assign w_zone   = r_lane & ZONE_MASK;
  assign w_lowbit = w_zone & (~w_zone + LANE_LEN'(1));

`ifdef COMBO_BONUS_EN
  assign w_score_step = (r_combo >= COMBO_W'(8)) ? 2'd2 : 2'd1;
`else
  assign w_score_step = 2'd1;
`endif

  assign w_score_sum  = {1'b0, r_score} + {{(SCORE_W-1){1'b0}}, w_score_step};
  assign w_score_inc  = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
  assign w_combo_inc  = (&r_combo) ? r_combo : r_combo + COMBO_W'(1);
  assign w_fallos_inc = r_fallos + 4'd1;

  always_comb begin
    w_state_nx   = r_state;
    w_lane_nx    = r_lane;
    w_lane_mid   = r_lane;
    w_score_nx   = r_score;
    w_combo_nx   = r_combo;
    w_fallos_nx  = r_fallos;
    w_acierto_nx = 1'b0;
    w_fallo_nx   = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nx  = S_PLAY;
          w_lane_nx   = '0;
          w_score_nx  = '0;
          w_combo_nx  = '0;
          w_fallos_nx = '0;
        end
      end
      S_PLAY: begin
        if (hit) begin
          if (|w_zone) begin
            w_lane_mid   = r_lane & ~w_lowbit;
            w_acierto_nx = 1'b1;
            w_score_nx   = w_score_inc;
            w_combo_nx   = w_combo_inc;
          end else begin
            w_combo_nx = '0;
          end
        end
        // Escape is judged after the hit, so a hit on the same tick saves the bottom note.
        if (tick) begin
          if (w_lane_mid[0]) begin
            w_fallo_nx  = 1'b1;
            w_fallos_nx = w_fallos_inc;
            w_combo_nx  = '0;
            if (w_fallos_inc == 4'(MAX_FALLOS)) w_state_nx = S_OVER;
          end
          w_lane_nx = {note_in, w_lane_mid[LANE_LEN-1:1]};
        end else begin
          w_lane_nx = w_lane_mid;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge stop) begin
    if (stop) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_score   <= '0;
      r_combo   <= '0;
      r_fallos  <= '0;
      r_acierto <= 1'b0;
      r_fallo   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lane    <= w_lane_nx;
      r_score   <= w_score_nx;
      r_combo   <= w_combo_nx;
      r_fallos  <= w_fallos_nx;
      r_acierto <= w_acierto_nx;
      r_fallo   <= w_fallo_nx;
    end
  end

  assign lane      = r_lane;
  assign score     = r_score;
  assign combo     = r_combo;
  assign fallos    = r_fallos;
  assign acierto   = r_acierto;
  assign fallo     = r_fallo;
  assign fin       = (r_state == S_OVER);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lane_judge.sv
// Bench for lane_judge: directed scenarios plus random play, checked against a game-rule model via a scoreboard queue.
module tb_lane_judge;

  localparam int LANE_LEN   = 16;
  localparam int HIT_ZONE   = 2;
  localparam int SCORE_W    = 10;
  localparam int COMBO_W    = 6;
  localparam int MAX_FALLOS = 8;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
  localparam int COMBO_MAX  = (1 << COMBO_W) - 1;
  localparam int EW         = LANE_LEN + SCORE_W + COMBO_W + 4 + 3;
`ifdef COMBO_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic stop, start, tick, note_in, hit;
  logic [LANE_LEN-1:0] lane;
  logic [SCORE_W-1:0]  score;
  logic [COMBO_W-1:0]  combo;
  logic [3:0]          fallos;
  logic                acierto, fallo, fin;
  logic [1:0]          dbg_state;

  always #5 clk = ~clk;

  lane_judge #(
    .LANE_LEN(LANE_LEN), .HIT_ZONE(HIT_ZONE), .SCORE_W(SCORE_W),
    .COMBO_W(COMBO_W), .MAX_FALLOS(MAX_FALLOS)
  ) dut (
    .clk(clk), .stop(stop), .start(start), .tick(tick), .note_in(note_in), .hit(hit),
    .lane(lane), .score(score), .combo(combo), .fallos(fallos),
    .acierto(acierto), .fallo(fallo), .fin(fin), .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: game state as plain integers and a bit array
  int m_state;  // 0 idle, 1 playing, 2 over
  bit m_lane[LANE_LEN];
  int m_score, m_combo, m_fallos;
  bit m_ac, m_fa;

  function automatic void model_reset();
    m_state = 0; m_score = 0; m_combo = 0; m_fallos = 0; m_ac = 0; m_fa = 0;
    for (int i = 0; i < LANE_LEN; i++) m_lane[i] = 0;
  endfunction

  function automatic void model_step(bit s, bit t, bit n, bit h);
    int found;
    m_ac = 0;
    m_fa = 0;
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_score = 0; m_combo = 0; m_fallos = 0;
        for (int i = 0; i < LANE_LEN; i++) m_lane[i] = 0;
      end
      return;
    end
    if (h) begin
      found = -1;
      for (int i = HIT_ZONE - 1; i >= 0; i--) if (m_lane[i]) found = i;
      if (found >= 0) begin
        m_lane[found] = 0;
        m_ac = 1;
        m_score = m_score + ((BONUS && m_combo >= 8) ? 2 : 1);
        if (m_score > SCORE_MAX) m_score = SCORE_MAX;
        if (m_combo < COMBO_MAX) m_combo++;
      end else begin
        m_combo = 0;
      end
    end
    if (t) begin
      if (m_lane[0]) begin
        m_fa = 1;
        m_fallos++;
        m_combo = 0;
        if (m_fallos == MAX_FALLOS) m_state = 2;
      end
      for (int i = 0; i < LANE_LEN - 1; i++) m_lane[i] = m_lane[i+1];
      m_lane[LANE_LEN-1] = n;
    end
  endfunction

  function automatic logic [EW-1:0] model_pack();
    logic [LANE_LEN-1:0] l;
    for (int i = 0; i < LANE_LEN; i++) l[i] = m_lane[i];
    return {l, SCORE_W'(m_score), COMBO_W'(m_combo), 4'(m_fallos), m_ac, m_fa, (m_state == 2)};
  endfunction

  // driver tasks
  task automatic cycle(input bit s, input bit t, input bit n, input bit h);
    @(negedge clk);
    start = s; tick = t; note_in = n; hit = h;
    model_step(s, t, n, h);
    exp_q.push_back(model_pack());
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1; start = 0; tick = 0; note_in = 0; hit = 0;
    #1;
    chk("stop_lane", int'(lane), 0);
    chk("stop_score", int'(score), 0);
    chk("stop_combo", int'(combo), 0);
    chk("stop_fallos", int'(fallos), 0);
    chk("stop_pulses", int'({acierto, fallo, fin}), 0);
    chk("stop_state_idle", int'(dbg_state), 0);
    model_reset();
    @(negedge clk);
    stop = 1'b0;
  endtask

  // scoreboard monitor: one registered output set per clock edge
  always @(posedge clk) begin
    logic [EW-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {lane, score, combo, fallos, acierto, fallo, fin};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got lane=%h score=%0d combo=%0d fallos=%0d ac=%b fa=%b fin=%b / expected lane=%h score=%0d combo=%0d fallos=%0d ac=%b fa=%b fin=%b",
                 $time, a[EW-1 -: LANE_LEN], a[SCORE_W+COMBO_W+6 : COMBO_W+7], a[COMBO_W+6:7], a[6:3], a[2], a[1], a[0],
                 e[EW-1 -: LANE_LEN], e[SCORE_W+COMBO_W+6 : COMBO_W+7], e[COMBO_W+6:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stop = 1'b1; start = 0; tick = 0; note_in = 0; hit = 0;
    model_reset();
    #12;
    do_stop();

    // one note travels the lane and escapes
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);
    settle();
    chk("travel_lane0", int'(lane), 1);
    cycle(0, 1, 0, 0);
    settle();
    chk("escape_fallo", int'(fallo), 1);
    chk("escape_fallos", int'(fallos), 1);

    // hit on lane[1] without tick
    do_stop();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    settle();
    chk("hit1_acierto", int'(acierto), 1);
    chk("hit1_lane", int'(lane), 0);
    chk("hit1_score", int'(score), 1);
    chk("hit1_combo", int'(combo), 1);

    // hit and tick together on lane[0]
    do_stop();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    settle();
    chk("ht_acierto", int'(acierto), 1);
    chk("ht_fallo", int'(fallo), 0);
    chk("ht_score", int'(score), 1);
    chk("ht_fallos", int'(fallos), 0);

    // two notes in the zone, one hit clears only the lowest
    do_stop();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    settle();
    chk("two_lane_after_hit", int'(lane), 2);
    cycle(0, 1, 0, 0);
    settle();
    chk("two_lane_after_tick", int'(lane), 1);
    chk("two_no_fallo", int'(fallo), 0);

    // game over after MAX_FALLOS escapes, frozen, then restart
    do_stop();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16 + MAX_FALLOS; i++) cycle(0, 1, 1, 0);
    settle();
    chk("over_fallos", int'(fallos), MAX_FALLOS);
    chk("over_fin", int'(fin), 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, i[0], 1);
    settle();
    chk("over_frozen_lane", int'(lane), 16'hFFFF);
    chk("over_frozen_fallos", int'(fallos), MAX_FALLOS);
    chk("over_frozen_score", int'(score), 0);
    cycle(1, 0, 0, 0);
    settle();
    chk("restart_fin", int'(fin), 0);
    chk("restart_score", int'(score), 0);
    chk("restart_lane", int'(lane), 0);

    // ten consecutive good hits, then stop mid-game
    do_stop();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1);
    settle();
    chk("streak_score", int'(score), BONUS ? 12 : 10);
    chk("streak_combo", int'(combo), 10);
    do_stop();

    // long streak to saturate score and combo
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0);
    for (int i = 0; i < 1100; i++) cycle(0, 1, 1, 1);
    settle();
    chk("sat_score", int'(score), SCORE_MAX);
    chk("sat_combo", int'(combo), COMBO_MAX);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    settle();
    chk("empty_zone_hit_combo", int'(combo), 0);

    // random play
    do_stop();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_stop();
      else cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end
    settle();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
